// File: rtl/fir_tap_sequencer_if.sv
// fir_tap_sequencer_if
//   Control bundle between the FIR tap sequencer, the sample source and the
//   MAC datapath (sample RAM, coefficient ROM, multiplier, accumulator and
//   output-hold register).
//   master : the sequencer. It takes filter_en, sample_in_valid and
//            overrun_clr, and drives the RAM/ROM addresses, the datapath
//            enables and clears, and the busy/result_valid/overrun status.
//   slave  : the environment (sample source plus datapath), the mirror view.
interface fir_tap_sequencer_if #(
  parameter int ADDR_W = 6
);
  logic              filter_en;
  logic              sample_in_valid;
  logic              overrun_clr;
  logic              sample_wr_en;
  logic [ADDR_W-1:0] sample_wr_addr;
  logic [ADDR_W-1:0] sample_rd_addr;
  logic [ADDR_W-1:0] coef_addr;
  logic              fir_en;
  logic              fir_mult_clr;
  logic              fir_accum_en;
  logic              fir_accum_clr;
  logic              busy;
  logic              result_valid;
  logic              overrun;

  modport master (
    input  filter_en, sample_in_valid, overrun_clr,
    output sample_wr_en, sample_wr_addr, sample_rd_addr, coef_addr,
           fir_en, fir_mult_clr, fir_accum_en, fir_accum_clr,
           busy, result_valid, overrun
  );

  modport slave (
    output filter_en, sample_in_valid, overrun_clr,
    input  sample_wr_en, sample_wr_addr, sample_rd_addr, coef_addr,
           fir_en, fir_mult_clr, fir_accum_en, fir_accum_clr,
           busy, result_valid, overrun
  );
endinterface

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer
//   Control sequencer for one multiply-accumulate FIR tap. Each accepted
//   sample is written into the circular sample RAM at wr_ptr. The sequencer
//   then walks coefficient address i = 0..NUM_TAPS-1 against sample address
//   (base - i), lets the multiplier pipeline drain, and dumps the accumulator
//   into the output-hold register with a result_valid pulse one cycle later.
// Ports
//   clk    : system clock
//   reset  : asynchronous, active-high; run is discarded, wr_ptr returns to 0
//   bus    : fir_tap_sequencer_if.master
//            in : filter_en, sample_in_valid, overrun_clr
//            out: sample_wr_en/sample_wr_addr (combinational from IDLE & strobe),
//                 fir_mult_clr (combinational from state), every other output
//                 registered: sample_rd_addr, coef_addr, fir_en, fir_accum_en,
//                 fir_accum_clr, busy, result_valid, overrun
module fir_tap_sequencer #(
  parameter int NUM_TAPS = 64,
  parameter int ADDR_W   = 6,
  parameter int PIPE_LAT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  fir_tap_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_MAC,
    S_DRAIN,
    S_DUMP
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_TAP   = ADDR_W'(NUM_TAPS - 1);
  localparam logic [ADDR_W-1:0] LAST_DRAIN = ADDR_W'(PIPE_LAT - 1);

  state_t              state;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   tap_cnt;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [ADDR_W-1:0]   coef_addr_q;
  logic                fir_en_q;
  logic                accum_clr_q;
  logic                busy_q;
  logic                result_valid_q;
  logic                overrun_q;
  logic [PIPE_LAT-1:0] mac_vld_p;

  logic accept;
  logic overrun_set;

  // filter_en only matters when a new run could start.
  assign accept      = (state == S_IDLE) && bus.sample_in_valid && bus.filter_en;
  assign overrun_set = (state != S_IDLE) && bus.sample_in_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_INIT;
      wr_ptr         <= '0;
      tap_cnt        <= '0;
      rd_addr_q      <= '0;
      coef_addr_q    <= '0;
      fir_en_q       <= 1'b0;
      accum_clr_q    <= 1'b1;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      mac_vld_p      <= '0;
    end else begin
      result_valid_q <= 1'b0;
      accum_clr_q    <= 1'b0;

      // Stage p0..p(PIPE_LAT-1): MAC-state indicator delayed to line up
      // each accumulator enable with the product of its address cycle.
      mac_vld_p[0] <= (state == S_MAC);
      for (int s = 1; s < PIPE_LAT; s++) begin
        mac_vld_p[s] <= mac_vld_p[s-1];
      end

      // A new overrun in the same cycle as a clear keeps the flag set.
      if (overrun_set) begin
        overrun_q <= 1'b1;
      end else if (bus.overrun_clr) begin
        overrun_q <= 1'b0;
      end

      unique case (state)
        S_INIT: begin
          state <= S_IDLE;
        end

        S_IDLE: begin
          if (accept) begin
            state       <= S_MAC;
            tap_cnt     <= '0;
            coef_addr_q <= '0;
            rd_addr_q   <= wr_ptr;  // base = newest sample
            fir_en_q    <= 1'b1;
            busy_q      <= 1'b1;
          end
        end

        S_MAC: begin
          if (tap_cnt == LAST_TAP) begin
            // Addresses hold their last value through DRAIN.
            state   <= S_DRAIN;
            tap_cnt <= '0;
          end else begin
            tap_cnt     <= tap_cnt + 1'b1;
            coef_addr_q <= tap_cnt + 1'b1;
            rd_addr_q   <= rd_addr_q - 1'b1;  // natural wrap 0 -> NUM_TAPS-1
          end
        end

        S_DRAIN: begin
          if (tap_cnt == LAST_DRAIN) begin
            state       <= S_DUMP;
            fir_en_q    <= 1'b0;
            accum_clr_q <= 1'b1;  // hold register loads, accumulator clears
          end else begin
            tap_cnt <= tap_cnt + 1'b1;
          end
        end

        S_DUMP: begin
          state          <= S_IDLE;
          wr_ptr         <= wr_ptr + 1'b1;
          busy_q         <= 1'b0;
          result_valid_q <= 1'b1;  // hold register is valid from this edge
        end

        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

  assign bus.sample_wr_en   = accept;
  assign bus.sample_wr_addr = wr_ptr;
  assign bus.fir_mult_clr   = (state == S_INIT) || (state == S_IDLE);
  assign bus.sample_rd_addr = rd_addr_q;
  assign bus.coef_addr      = coef_addr_q;
  assign bus.fir_en         = fir_en_q;
  assign bus.fir_accum_en   = mac_vld_p[PIPE_LAT-1];
  assign bus.fir_accum_clr  = accum_clr_q;
  assign bus.busy           = busy_q;
  assign bus.result_valid   = result_valid_q;
  assign bus.overrun        = overrun_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer
//   Two sequencers: an 8-tap one driving a behavioural datapath (sample RAM,
//   ROM h[i]=i+1, two-stage multiplier, 48-bit accumulator, hold register)
//   for the impulse/data checks, and a default 64-tap one for counts,
//   overrun, wrap, back-to-back cadence and mid-run reset.
module tb_fir_tap_sequencer;

  logic clk = 1'b0;
  logic reset8 = 1'b1;
  logic reset64 = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_tap_sequencer_if #(.ADDR_W(3)) if8 ();
  fir_tap_sequencer_if #(.ADDR_W(6)) if64 ();

  fir_tap_sequencer #(.NUM_TAPS(8), .ADDR_W(3), .PIPE_LAT(2)) dut8 (
    .clk   (clk),
    .reset (reset8),
    .bus   (if8)
  );

  fir_tap_sequencer #(.NUM_TAPS(64), .ADDR_W(6), .PIPE_LAT(2)) dut64 (
    .clk   (clk),
    .reset (reset64),
    .bus   (if64)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  // ---------------- 8-tap behavioural datapath ----------------
  logic signed [23:0] sample_data8 = '0;
  logic signed [23:0] ram8 [8] = '{default: '0};
  logic signed [47:0] prod_p1 = '0;
  logic signed [47:0] prod_p2 = '0;
  logic signed [47:0] acc8 = '0;
  logic signed [47:0] hold8 = '0;

  always @(posedge clk) begin
    if (if8.sample_wr_en) ram8[if8.sample_wr_addr] <= sample_data8;
    if (if8.fir_mult_clr) begin
      prod_p1 <= '0;
      prod_p2 <= '0;
    end else if (if8.fir_en) begin
      prod_p1 <= 48'(ram8[if8.sample_rd_addr]) * 48'(int'(if8.coef_addr) + 1);
      prod_p2 <= prod_p1;
    end
    if (if8.fir_accum_clr) begin
      hold8 <= acc8;
      acc8  <= '0;
    end else if (if8.fir_accum_en) begin
      acc8 <= acc8 + prod_p2;
    end
  end

  // ---------------- scoreboards ----------------
  int exp8_val [$];
  int exp8_cyc [$];
  int exp64_cyc [$];

  always @(negedge clk) begin
    if (!reset8 && if8.result_valid) begin
      if (exp8_val.size() == 0) begin
        fail_now("rv8_spurious");
      end else begin
        check("result8", longint'(hold8 >>> 8), exp8_val.pop_front());
        check("rv8_cycle", cyc, exp8_cyc.pop_front());
      end
    end
  end

  int   acc_en_cnt = 0;
  int   acc_clr_cnt = 0;
  int   busy_cnt = 0;
  int   acc_rise_cyc = -1;
  int   busy_rise_cyc = -1;
  logic acc_prev = 1'b0;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    if (!reset64) begin
      if (if64.fir_accum_en)  acc_en_cnt++;
      if (if64.fir_accum_clr) acc_clr_cnt++;
      if (if64.busy)          busy_cnt++;
      if (if64.fir_accum_en && !acc_prev) acc_rise_cyc = cyc;
      if (if64.busy && !busy_prev)        busy_rise_cyc = cyc;
      acc_prev  = if64.fir_accum_en;
      busy_prev = if64.busy;
      if (if64.result_valid) begin
        if (exp64_cyc.size() == 0) fail_now("rv64_spurious");
        else check("rv64_cycle", cyc, exp64_cyc.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers (called just after a negedge) ----------------
  task automatic strobe8(input logic signed [23:0] d, input int exp_val, input int exp_addr);
    if8.sample_in_valid = 1'b1;
    sample_data8 = d;
    #1;
    check("wr_en8", if8.sample_wr_en, 1);
    check("wr_addr8", if8.sample_wr_addr, exp_addr);
    exp8_val.push_back(exp_val);
    exp8_cyc.push_back(cyc + 12);
    @(negedge clk);
    if8.sample_in_valid = 1'b0;
  endtask

  task automatic strobe64(input logic fen, input logic oclr, input logic exp_we, input int exp_addr);
    if64.filter_en = fen;
    if64.sample_in_valid = 1'b1;
    if64.overrun_clr = oclr;
    #1;
    check("wr_en64", if64.sample_wr_en, exp_we);
    if (exp_we) begin
      check("wr_addr64", if64.sample_wr_addr, exp_addr);
      exp64_cyc.push_back(cyc + 68);
    end
    @(negedge clk);
    if64.sample_in_valid = 1'b0;
    if64.overrun_clr = 1'b0;
    if64.filter_en = 1'b1;
  endtask

  logic signed [23:0] samp8 [12] = '{24'sh000100, 24'sh0, 24'sh0, 24'sh0, 24'sh0, 24'sh0,
                                     24'sh0, 24'sh0, 24'sh0, 24'sh000300, 24'sh000200,
                                     -24'sh000100};
  int exp8 [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 3, 8, 12};

  initial begin
    int c0, a0, k0, b0, bad;
    if8.filter_en = 1'b1;  if8.sample_in_valid = 1'b0;  if8.overrun_clr = 1'b0;
    if64.filter_en = 1'b1; if64.sample_in_valid = 1'b0; if64.overrun_clr = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state of the 64-tap sequencer (held in reset).
    check("rst_mult_clr", if64.fir_mult_clr, 1);
    check("rst_accum_clr", if64.fir_accum_clr, 1);
    check("rst_fir_en", if64.fir_en, 0);
    check("rst_accum_en", if64.fir_accum_en, 0);
    check("rst_busy", if64.busy, 0);
    check("rst_rv", if64.result_valid, 0);
    check("rst_overrun", if64.overrun, 0);
    check("rst_wr_addr", if64.sample_wr_addr, 0);

    // Impulse and data patterns on the 8-tap sequencer, back-to-back every 12 cycles.
    reset8 = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      strobe8(samp8[k], exp8[k], k % 8);
      if (k == 10) begin
        repeat (4) @(negedge clk);
        if8.sample_in_valid = 1'b1;
        sample_data8 = 24'sh7FFFFF;
        #1;
        check("ovr8_no_write", if8.sample_wr_en, 0);
        @(negedge clk);
        if8.sample_in_valid = 1'b0;
        check("ovr8_set", if8.overrun, 1);
        if8.overrun_clr = 1'b1;
        @(negedge clk);
        if8.overrun_clr = 1'b0;
        check("ovr8_clr", if8.overrun, 0);
        repeat (5) @(negedge clk);
      end else begin
        repeat (11) @(negedge clk);
      end
    end
    repeat (2) @(negedge clk);

    // 64-tap: release reset, INIT then IDLE.
    reset64 = 1'b0;
    #1;
    check("init_accum_clr", if64.fir_accum_clr, 1);
    check("init_mult_clr", if64.fir_mult_clr, 1);
    @(negedge clk);
    check("idle_accum_clr", if64.fir_accum_clr, 0);
    check("idle_mult_clr", if64.fir_mult_clr, 1);

    // filter_en low in IDLE: strobe ignored.
    strobe64(1'b0, 1'b0, 1'b0, 0);
    check("fen0_busy", if64.busy, 0);
    check("fen0_overrun", if64.overrun, 0);
    @(negedge clk);

    // Counts run; filter_en dropped mid-run must not stop it.
    a0 = acc_en_cnt; k0 = acc_clr_cnt; b0 = busy_cnt; c0 = cyc;
    strobe64(1'b1, 1'b0, 1'b1, 0);
    repeat (9) @(negedge clk);
    if64.filter_en = 1'b0;
    @(negedge clk);
    if64.filter_en = 1'b1;
    repeat (59) @(negedge clk);
    check("busy_rise", busy_rise_cyc, c0 + 1);
    check("acc_rise", acc_rise_cyc, c0 + 3);
    repeat (2) @(negedge clk);
    check("acc_en_count", acc_en_cnt - a0, 64);
    check("acc_clr_count", acc_clr_cnt - k0, 1);
    check("busy_count", busy_cnt - b0, 67);

    // Overrun: second strobe at cycle 30, then set-wins, then clear.
    strobe64(1'b1, 1'b0, 1'b1, 1);
    repeat (29) @(negedge clk);
    strobe64(1'b1, 1'b0, 1'b0, 0);
    check("ovr_set", if64.overrun, 1);
    strobe64(1'b1, 1'b1, 1'b0, 0);
    check("ovr_set_wins", if64.overrun, 1);
    if64.overrun_clr = 1'b1;
    @(negedge clk);
    if64.overrun_clr = 1'b0;
    check("ovr_clr", if64.overrun, 0);
    repeat (35) @(negedge clk);

    // Back-to-back every 68 cycles, wrapping wr_ptr; trace reads for base 0 and 1.
    for (int k = 0; k < 68; k++) begin
      strobe64(1'b1, 1'b0, 1'b1, (2 + k) % 64);
      if (((2 + k) % 64) < 2) begin
        bad = 0;
        for (int i = 0; i < 64; i++) begin
          if (if64.sample_rd_addr !== 6'((((2 + k) % 64) - i) & 63)) bad++;
          if (if64.coef_addr !== 6'(i)) bad++;
          if (if64.fir_en !== 1'b1) bad++;
          @(negedge clk);
        end
        check("addr_trace", bad, 0);
        repeat (3) @(negedge clk);
      end else begin
        repeat (67) @(negedge clk);
      end
    end
    check("b2b_no_overrun", if64.overrun, 0);

    // Reset at MAC cycle 20.
    strobe64(1'b1, 1'b0, 1'b1, 6);
    repeat (19) @(negedge clk);
    check("pre_rst_accum_en", if64.fir_accum_en, 1);
    reset64 = 1'b1;
    #1;
    void'(exp64_cyc.pop_back());
    check("midrst_fir_en", if64.fir_en, 0);
    check("midrst_accum_en", if64.fir_accum_en, 0);
    check("midrst_busy", if64.busy, 0);
    check("midrst_accum_clr", if64.fir_accum_clr, 1);
    @(negedge clk);
    reset64 = 1'b0;
    #1;
    check("reinit_accum_clr", if64.fir_accum_clr, 1);
    check("reinit_mult_clr", if64.fir_mult_clr, 1);
    @(negedge clk);
    check("reidle_accum_clr", if64.fir_accum_clr, 0);
    strobe64(1'b1, 1'b0, 1'b1, 0);
    repeat (70) @(negedge clk);

    check("sb8_drained", exp8_val.size(), 0);
    check("sb64_drained", exp64_cyc.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_tap_sequencer.md
# fir_tap_sequencer

Control sequencer for one multiply-accumulate FIR tap datapath: multiplier, 48-bit accumulator and output-hold register. On each incoming audio sample it writes the sample into a circular sample RAM. It then steps coefficient and sample addresses through all taps and drives the multiplier and accumulator enables and clears with pipeline-aligned timing. Finally it dumps the sum into the tap's output-hold register and flags the result valid. It sits between the I2S sample source and the FIR tap, and owns the sample-RAM and coefficient-ROM address ports.

## Interface
- NUM_TAPS, 64, taps per output sample; power of two, 4..1024.
- ADDR_W, 6, log2(NUM_TAPS).
- PIPE_LAT, 2, cycles from address issue to valid multiplier product (RAM/ROM read plus multiplier latency), 1..4.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- filter_en  in  1  when low, sample_in_valid is ignored; sampled only in IDLE.
- sample_in_valid  in  1  one-cycle strobe: new 24-bit sample present on the write-data bus.
- overrun_clr  in  1  clears the sticky overrun flag.
- sample_wr_en  out  1  sample-RAM write strobe.
- sample_wr_addr  out  ADDR_W  sample-RAM write address (= wr_ptr).
- sample_rd_addr  out  ADDR_W  sample-RAM read address.
- coef_addr  out  ADDR_W  coefficient-ROM address.
- fir_en  out  1  multiplier CE.
- fir_mult_clr  out  1  multiplier SCLR.
- fir_accum_en  out  1  accumulator CE.
- fir_accum_clr  out  1  accumulator SCLR; also the output-hold load strobe.
- busy  out  1  high from MAC entry through DUMP.
- result_valid  out  1  one-cycle pulse when the tap's data_out holds the new sum.
- overrun  out  1  sticky: a sample arrived while busy and was dropped.

## Operation
- States: INIT, IDLE, MAC, DRAIN, DUMP.
- Reset: go to INIT. wr_ptr=0, tap counter=0, all outputs 0 except fir_mult_clr=1 and fir_accum_clr=1.
- INIT (1 cycle): assert fir_mult_clr and fir_accum_clr, then go to IDLE. The hold register takes whatever the accumulator held; no result_valid pulse.
- IDLE
  - fir_mult_clr=1; all other strobes 0.
  - On sample_in_valid with filter_en=1: sample_wr_en=1 combinationally at wr_ptr; latch base=wr_ptr and go to MAC.
- MAC (NUM_TAPS cycles, tap counter i=0..NUM_TAPS-1)
  - coef_addr=i; sample_rd_addr=(base-i) mod NUM_TAPS (natural ADDR_W wrap); fir_en=1.
  - Leave after i=NUM_TAPS-1.
- DRAIN (PIPE_LAT cycles): fir_en=1; addresses hold their last value.
- fir_accum_en is the MAC-state indicator delayed by PIPE_LAT registers. It is high for exactly NUM_TAPS cycles, each aligned to its product.
- DUMP (1 cycle)
  - Entered the cycle after the last fir_accum_en, so the accumulator's 1-cycle Q latency has settled.
  - fir_accum_clr=1: the hold register loads the final sum and the accumulator clears.
  - wr_ptr increments (mod NUM_TAPS); go to IDLE.
  - result_valid pulses the following cycle, which is also the first IDLE cycle.
- sample_in_valid while not IDLE: no write; set overrun. If overrun_clr and a new overrun occur in the same cycle, the set wins.
- filter_en low: ignored once a run has started; the run completes.

## Timing
- Strobe at cycle 0 (IDLE) → MAC cycles 1..NUM_TAPS.
- fir_accum_en high cycles 1+PIPE_LAT .. NUM_TAPS+PIPE_LAT.
- DUMP at cycle NUM_TAPS+PIPE_LAT+1.
- result_valid at cycle NUM_TAPS+PIPE_LAT+2.
- busy is high cycles 1..NUM_TAPS+PIPE_LAT+1.
- Minimum sample period is NUM_TAPS+PIPE_LAT+2 cycles: 68 for the defaults. A strobe on the result_valid cycle is accepted.
- Reset mid-run: asynchronous. All strobes drop immediately, wr_ptr returns to 0, the run is discarded, and INIT follows the reset release.
- All outputs are registered except sample_wr_en/sample_wr_addr (decoded from IDLE & strobe) and fir_mult_clr (decoded from state).

## Test plan
- Impulse: coefficients h[i]=i+1, sample 0x000100 then zeros, NUM_TAPS=8 → the first result equals h[0]·0x100 scaled by the tap's >>8; the next results step through h[1..7]; result_valid at exactly cycle 12 after each strobe.
- Counts: one run with defaults → exactly 64 fir_accum_en cycles, 1 fir_accum_clr, and busy high for 67 cycles.
- Overrun: second strobe at cycle 30 of a run → no sample_wr_en, overrun=1, and the current result is unaffected. overrun_clr → overrun=0.
- Wrap: 70 strobes → sample_wr_addr wraps 63→0, and the run after the wrap reads addresses base, base-1… wrapping 0→63.
- Reset at MAC cycle 20 → fir_en and fir_accum_en are 0 the same cycle. After release, INIT asserts both clears for one cycle, and the next sample writes address 0.
- Back-to-back: strobes exactly every 68 cycles → no overrun, and every result_valid is present.
